// File: rtl/i2c_mon_pkg.sv
// Shared types for the passive I2C bus monitor: record tags, FSM states
// and the packed record pushed into the record FIFO.
package i2c_mon_pkg;

    typedef enum logic [2:0] {
        TAG_START_ADDR   = 3'd0,
        TAG_RESTART_ADDR = 3'd1,
        TAG_DATA         = 3'd2,
        TAG_STOP         = 3'd3,
        TAG_TIMEOUT      = 3'd4
    } rec_tag_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_SKIP
    } mon_state_e;

    localparam int REC_W = 3 + 8 + 1;

    typedef struct packed {
        rec_tag_e    tag;
        logic [7:0]  data;
        logic        ack;
    } rec_t;

    // Bits with a 0 in mask are don't-care; an all-zero mask matches every address.
    function automatic logic addr_hit(input logic [6:0] addr,
                                      input logic [6:0] match,
                                      input logic [6:0] mask);
        return ((addr ^ match) & mask) == 7'd0;
    endfunction

endpackage

// File: rtl/i2c_mon_fifo.sv
// Synchronous first-word-fall-through FIFO; when empty the read port keeps
// presenting the most recently popped word.
module i2c_mon_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;
    logic             wr_en, rd_en;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign rd_en      = pop_i & ~empty_o;
    assign wr_en      = push_i & (~full_o | rd_en);
    assign pop_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    // NOTE: the storage array is deliberately not reset; count_q alone decides
    // which entries are meaningful, so only the control state needs a reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C monitor: synchronise and glitch-filter SCL/SDA, decode bus
// conditions, frame bytes with their ACK, and queue tagged records.
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    input  logic [6:0]       addr_match,
    input  logic [6:0]       addr_mask,
    input  logic             clr_overflow,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [2:0]       rec_tag,
    output logic [7:0]       rec_data,
    output logic             rec_ack,
    output logic             bus_busy,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

    // Line index 0 is SCL, 1 is SDA.
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [1:0][3:0] flt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            flt_cnt_q   <= '0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so the pipeline
            // stages all see the previous cycle's values regardless of order.
            sync1_q     <= {sda_i, scl_i};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == FLT_LAST) begin
                    filt_q[i]    <= sync2_q[i];
                    flt_cnt_q[i] <= '0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_p, sda_p;
    logic scl_rise_q, start_q, stop_q, sda_smp_q;

    assign scl_f = filt_q[0];
    assign sda_f = filt_q[1];
    assign scl_p = filt_prev_q[0];
    assign sda_p = filt_prev_q[1];

    // A simultaneous SCL change breaks the "SCL high on both samples" term,
    // so START/STOP are suppressed and only the SCL edge survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_rise_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_smp_q  <= 1'b1;
        end else begin
            scl_rise_q <= scl_f & ~scl_p;
            start_q    <= scl_f & scl_p & sda_p & ~sda_f;
            stop_q     <= scl_f & scl_p & ~sda_p & sda_f;
            sda_smp_q  <= sda_f;
        end
    end

    mon_state_e       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             restart_q, restart_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             push_q, push_d;
    rec_t             push_rec_q, push_rec_d;
    logic [3:0]       partial;

    // Every STOP is preceded by an SCL rise that is not a data bit, so that
    // last rise is excluded from the reported partial-bit count.
    assign partial = (bit_cnt_q == 4'd0) ? 4'd0 : bit_cnt_q - 4'd1;

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        restart_d  = restart_q;
        push_d     = 1'b0;
        push_rec_d = push_rec_q;
        tmo_cnt_d  = (state_q == ST_IDLE || scl_f) ? '0 : tmo_cnt_q + TMO_W'(1);

        if (state_q != ST_IDLE && !scl_f && tmo_cnt_q == TMO_LAST) begin
            push_d     = 1'b1;
            push_rec_d = '{tag: TAG_TIMEOUT, data: 8'h00, ack: 1'b0};
            state_d    = ST_IDLE;
            tmo_cnt_d  = '0;
        end else if (start_q) begin
            state_d   = ST_ADDR;
            restart_d = (state_q != ST_IDLE);
            bit_cnt_d = 4'd0;
        end else if (stop_q && state_q != ST_IDLE) begin
            if (state_q == ST_DATA) begin
                push_d     = 1'b1;
                push_rec_d = '{tag: TAG_STOP, data: {4'd0, partial}, ack: 1'b0};
            end
            state_d = ST_IDLE;
        end else if (scl_rise_q && (state_q == ST_ADDR || state_q == ST_DATA)) begin
            if (bit_cnt_q != 4'd8) begin
                shift_d   = {shift_q[6:0], sda_smp_q};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                bit_cnt_d = 4'd0;
                if (state_q == ST_DATA) begin
                    push_d     = 1'b1;
                    push_rec_d = '{tag: TAG_DATA, data: shift_q, ack: ~sda_smp_q};
                end else if (addr_hit(shift_q[7:1], addr_match, addr_mask)) begin
                    push_d     = 1'b1;
                    push_rec_d = '{tag: restart_q ? TAG_RESTART_ADDR : TAG_START_ADDR,
                                   data: shift_q, ack: ~sda_smp_q};
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_SKIP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            restart_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            push_q     <= 1'b0;
            push_rec_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            restart_q  <= restart_d;
            tmo_cnt_q  <= tmo_cnt_d;
            push_q     <= push_d;
            push_rec_q <= push_rec_d;
        end
    end

    assign bus_busy = (state_q != ST_IDLE);

    logic             fifo_full, fifo_empty, pop, drop;
    logic [REC_W-1:0] fifo_rd;
    rec_t             head;

    i2c_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_q),
        .push_data_i (push_rec_q),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head      = fifo_rd;
    assign rec_valid = ~fifo_empty;
    assign rec_tag   = head.tag;
    assign rec_data  = head.data;
    assign rec_ack   = head.ack;
    assign pop       = rec_valid & rec_ready;
    assign drop      = push_q & fifo_full & ~pop;

    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A drop in the same cycle as clr_overflow wins and restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)          drop_cnt_d = CNT_W'(1);
            else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed plus randomized bench for i2c_bus_monitor: bit-bangs the bus and
// compares the record stream against a transaction-level expectation queue.
module tb_i2c_bus_monitor;

    localparam int FILTER_LEN  = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int TIMEOUT_CYC = 200;
    localparam int CNT_W       = 16;
    localparam int T           = 8;

    localparam logic [2:0] T_START   = 3'd0;
    localparam logic [2:0] T_RESTART = 3'd1;
    localparam logic [2:0] T_DATA    = 3'd2;
    localparam logic [2:0] T_STOP    = 3'd3;
    localparam logic [2:0] T_TIMEOUT = 3'd4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             scl, sda;
    logic [6:0]       addr_match, addr_mask;
    logic             clr_overflow;
    logic             rec_valid, rec_ready;
    logic [2:0]       rec_tag;
    logic [7:0]       rec_data;
    logic             rec_ack;
    logic             bus_busy, overflow;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    i2c_bus_monitor #(
        .FILTER_LEN  (FILTER_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl),
        .sda_i        (sda),
        .addr_match   (addr_match),
        .addr_mask    (addr_mask),
        .clr_overflow (clr_overflow),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_tag      (rec_tag),
        .rec_data     (rec_data),
        .rec_ack      (rec_ack),
        .bus_busy     (bus_busy),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    bit          model_sel;

    always @(negedge clk) begin
        if (rst_n && rec_valid && rec_ready) got_q.push_back({rec_tag, rec_data, rec_ack});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: is this 8-bit address byte selected by the filter?
    function automatic bit addr_selected(input logic [7:0] ab);
        for (int i = 0; i < 7; i++)
            if (addr_mask[i] && (ab[i+1] != addr_match[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic bus_start();
        sda = 1'b0; clks(T); scl = 1'b0; clks(T);
    endtask

    task automatic bus_restart();
        sda = 1'b1; clks(T); scl = 1'b1; clks(T); sda = 1'b0; clks(T); scl = 1'b0; clks(T);
    endtask

    task automatic bus_stop();
        sda = 1'b0; clks(T); scl = 1'b1; clks(T); sda = 1'b1; clks(T);
    endtask

    task automatic bus_bit(input logic b);
        sda = b; clks(T); scl = 1'b1; clks(T); scl = 1'b0; clks(T);
    endtask

    task automatic bus_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(~ack);
    endtask

    task automatic send_addr(input bit restart, input logic [7:0] ab, input logic ack);
        if (restart) bus_restart(); else bus_start();
        bus_byte(ab, ack);
        model_sel = addr_selected(ab);
        if (model_sel) exp_q.push_back({restart ? T_RESTART : T_START, ab, ack});
    endtask

    task automatic send_data(input logic [7:0] b, input logic ack);
        bus_byte(b, ack);
        if (model_sel) exp_q.push_back({T_DATA, b, ack});
    endtask

    task automatic send_stop(input int partial);
        for (int i = 0; i < partial; i++) bus_bit(1'($urandom));
        bus_stop();
        if (model_sel) exp_q.push_back({T_STOP, 8'(partial), 1'b0});
        model_sel = 1'b0;
    endtask

    task automatic drain_compare(input string name);
        int n;
        clks(40);
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_rec%0d", name, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rec_valid"}, rec_valid, 0);
        check({name, "_rec_tag"},   rec_tag,   0);
        check({name, "_rec_data"},  rec_data,  0);
        check({name, "_rec_ack"},   rec_ack,   0);
        check({name, "_bus_busy"},  bus_busy,  0);
        check({name, "_overflow"},  overflow,  0);
        check({name, "_drop_cnt"},  drop_cnt,  0);
    endtask

    task automatic glitch(input int n, output bit saw);
        saw = 1'b0;
        sda = 1'b0; clks(n); sda = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clks(1);
            if (bus_busy) saw = 1'b1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          saw;
        logic [7:0]  ab;
        logic [11:0] held;
        int          dropped;

        rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
        addr_match = 7'h00; addr_mask = 7'h00;
        clr_overflow = 1'b0; rec_ready = 1'b1;
        model_sel = 1'b0;
        clks(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        clks(5);

        // Plain write to 0x50 with mask 0.
        send_addr(1'b0, 8'hA0, 1'b1);
        check("busy_in_txn", bus_busy, 1);
        send_data(8'h10, 1'b1);
        send_data(8'h5A, 1'b1);
        send_stop(0);
        clks(10);
        check("busy_after_stop", bus_busy, 0);
        drain_compare("write");

        // Read with repeated START and a final NACK.
        send_addr(1'b0, 8'hA0, 1'b1);
        send_data(8'h03, 1'b1);
        send_addr(1'b1, 8'hA1, 1'b1);
        send_data(8'h77, 1'b0);
        send_stop(0);
        drain_compare("restart");

        // Exact-address filter: 0x51 is skipped, 0x50 is recorded.
        addr_match = 7'h50; addr_mask = 7'h7F;
        send_addr(1'b0, 8'hA2, 1'b1);
        send_data(8'h11, 1'b1);
        send_stop(0);
        send_addr(1'b0, 8'hA0, 1'b1);
        send_data(8'h22, 1'b1);
        send_stop(0);
        drain_compare("mask");

        // SDA glitch while SCL high: one sample short of the filter length is ignored.
        glitch(FILTER_LEN - 1, saw);
        check("glitch_short", saw, 0);
        glitch(FILTER_LEN, saw);
        check("glitch_long", saw, 1);
        check("glitch_long_idle", bus_busy, 0);
        drain_compare("glitch");

        // Randomized transactions.
        for (int k = 0; k < 6; k++) begin
            addr_match = 7'($urandom);
            case ($urandom_range(0, 2))
                0:       addr_mask = 7'h00;
                1:       addr_mask = 7'h7F;
                default: addr_mask = 7'($urandom);
            endcase
            ab = {($urandom_range(0, 1) == 1) ? addr_match : 7'($urandom), 1'($urandom)};
            send_addr(1'b0, ab, 1'($urandom));
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) send_data(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                ab = {($urandom_range(0, 1) == 1) ? addr_match : 7'($urandom), 1'($urandom)};
                send_addr(1'b1, ab, 1'($urandom));
                send_data(8'($urandom), 1'($urandom));
            end
            send_stop($urandom_range(0, 7));
            drain_compare($sformatf("rand%0d", k));
        end

        // Overflow: 22 records into a 16-deep FIFO with the consumer stalled.
        addr_match = 7'h00; addr_mask = 7'h00;
        rec_ready = 1'b0;
        send_addr(1'b0, 8'hA0, 1'b1);
        for (int i = 0; i < 20; i++) send_data(8'(i * 7 + 1), 1'b1);
        send_stop(0);
        clks(10);
        dropped = exp_q.size() - FIFO_DEPTH;
        check("ovf_flag", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, dropped);
        check("ovf_valid", rec_valid, 1);
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        held = exp_q[FIFO_DEPTH-1];
        clr_overflow = 1'b1; clks(1); clr_overflow = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);
        rec_ready = 1'b1;
        drain_compare("overflow");
        check("empty_valid", rec_valid, 0);
        check("empty_hold", {rec_tag, rec_data, rec_ack}, held);

        // Timeout: SCL held low after three bits of a data byte.
        send_addr(1'b0, 8'hA0, 1'b1);
        send_data(8'hC3, 1'b1);
        for (int i = 0; i < 3; i++) bus_bit(1'b1);
        exp_q.push_back({T_TIMEOUT, 8'h00, 1'b0});
        model_sel = 1'b0;
        clks(TIMEOUT_CYC + 20);
        check("timeout_idle", bus_busy, 0);
        sda = 1'b1; clks(T); scl = 1'b1; clks(T);
        drain_compare("timeout");

        // STOP after five bits of a matched byte.
        send_addr(1'b0, 8'hA0, 1'b1);
        send_data(8'h42, 1'b1);
        send_stop(5);
        drain_compare("partial");

        // Reset in the middle of a byte with a record still queued.
        rec_ready = 1'b0;
        send_addr(1'b0, 8'hA0, 1'b1);
        for (int i = 0; i < 4; i++) bus_bit(1'b0);
        check("pre_reset_valid", rec_valid, 1);
        rst_n = 1'b0;
        clks(2);
        check_all_zero("mid_reset");
        scl = 1'b1; sda = 1'b1;
        clks(2);
        rst_n = 1'b1;
        exp_q.delete();
        model_sel = 1'b0;
        clks(5);
        rec_ready = 1'b1;
        drain_compare("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
